demux8_collect: RTL and testbench
=================================

Name: demux8_collect

Overview:
- Registered 1-to-8 demultiplexer and byte collector. It is the inverse of the team's 8:1 bit-select mux.
- Each accepted input transfer steers a single bit into the lane addressed by `sel`.
- Once all 8 lanes have been written, the assembled byte is presented on a valid/ready output handshake.
- Sits downstream of serial or bit-select datapaths that need to rebuild a parallel word from individually addressed bits.

Parameters:
- N, 8, number of output lanes; must be a power of 2, minimum 2.
- SW, 3, select width; must equal log2(N).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- in_bit  input  1  data bit to steer.
- sel  input  SW  destination lane index.
- in_valid  input  1  in_bit and sel are valid this cycle.
- in_ready  output  1  block can accept an input transfer this cycle.
- out  output  N  assembled word; out[k] holds the last bit written to lane k.
- out_valid  output  1  all N lanes written; out is stable.
- out_ready  input  1  consumer accepts out this cycle.
- lane_mask  output  N  lane k written since the last drain or reset.
- dup_err  output  1  sticky flag; a lane was written twice within one collection.

Behaviour:
- Everything is registered on rising clk. Reset is synchronous and active-high.
- While rst=1: out=0, lane_mask=0, out_valid=0, dup_err=0. in_ready reads 0 during reset cycles.
- States:
  - COLLECT: out_valid=0.
  - FULL: out_valid=1.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready. This is combinational pass-through, so an input may be accepted in the same cycle as a drain.
- COLLECT, on accept:
  - out[sel] <= in_bit; lane_mask[sel] <= 1. Other lanes are unchanged.
  - If lane_mask[sel] was already 1: the bit is overwritten, lane_mask is unchanged, and dup_err <= 1.
- COLLECT -> FULL on the clock edge where the next lane_mask equals all ones. out_valid rises 1 cycle after the accept that completes the mask.
- FULL, hold: if out_ready=0, out and lane_mask are held and in_ready=0. in_valid is ignored, with no side effects.
- FULL, drain: out_valid && out_ready at an edge.
  - Without a simultaneous accept: lane_mask <= 0 and state -> COLLECT.
  - With a simultaneous accept: lane_mask <= one-hot(sel), out[sel] <= in_bit, state -> COLLECT.
  - A simultaneous accept is never counted as a duplicate.
- Data retention: out is not cleared on drain. Stale lanes keep their old value, and out is meaningful only while out_valid=1.
- N=1 collections are impossible. Minimum latency from the first accept to out_valid is N cycles, when one bit is accepted per cycle.
- dup_err clears only on rst.
- Reset mid-collection or in FULL: the partial word is discarded, all outputs return to reset values on the next edge, and no out_valid is produced.
- sel is always in range because it is SW bits wide, so there is no out-of-range case. Input values are don't-care when in_valid=0.

Test Plan:
1. Reset, then accept sel=0..7 with in_bit pattern 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=0.
   -> out_valid=1 on the cycle after the 8th accept; out=8'b01001101; lane_mask=8'hFF; in_ready=0.
2. From FULL, hold out_ready=0 for 5 cycles while driving in_valid=1.
   -> out and lane_mask unchanged; no state change; dup_err=0.
3. From FULL, assert out_ready=1 with in_valid=1, sel=3, in_bit=1 in the same cycle.
   -> next cycle: out_valid=0, lane_mask=8'h08, out[3]=1, dup_err=0.
4. Out-of-order fill sel=7,2,5,0,6,1,4,3.
   -> out_valid only after sel=3 is accepted; each bit lands in its own lane.
5. Write sel=2 with in_bit=1, then sel=2 with in_bit=0.
   -> out[2]=0; lane_mask=8'h04; dup_err=1, which stays set after a later full drain.
6. Accept 5 lanes, then pulse rst for 1 cycle.
   -> out=0, lane_mask=0, out_valid=0, dup_err=0; a fresh 8-lane fill then completes normally.

Source files
------------

// File: rtl/demux8_collect_if.sv
// Handshake bundle for the bit-steering demux / byte collector.
// Input side: a transfer happens on a rising clk edge where in_valid && in_ready.
// Output side: a drain happens on a rising clk edge where out_valid && out_ready.
// A producer must hold in_bit/sel stable while in_valid is high and it has not
// yet seen in_ready. The collector holds out stable while out_valid is high and
// it has not yet seen out_ready.
interface demux8_collect_if #(
  parameter int N  = 8,
  parameter int SW = 3
);
  logic          in_bit;
  logic [SW-1:0] sel;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  lane_mask;
  logic          dup_err;

  // Collector side.
  modport slave (
    input  in_bit, sel, in_valid, out_ready,
    output in_ready, out, out_valid, lane_mask, dup_err
  );

  // Producer/consumer side.
  modport master (
    output in_bit, sel, in_valid, out_ready,
    input  in_ready, out, out_valid, lane_mask, dup_err
  );
endinterface

// File: rtl/demux8_collect.sv
// Registered 1-to-N demultiplexer and word collector.
// Each accepted transfer writes one bit into the lane addressed by sel. When
// every lane has been written, the assembled word is offered on the output
// handshake. N must be a power of two (at least 2) and SW = log2(N).
module demux8_collect #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic             clk,
  input  logic             rst,
  demux8_collect_if.slave  bus,
  output logic             state_dbg
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   word_q, word_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           dup_q, dup_d;
  logic           accept;
  logic           drain;

  // Handshake qualifiers; in_ready is held low while reset is asserted.
  always_comb begin
    bus.in_ready  = !rst && ((state_q != FULL) || bus.out_ready);
    bus.out_valid = (state_q == FULL);
    accept        = bus.in_valid && bus.in_ready;
    drain         = bus.out_valid && bus.out_ready;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      word_q  <= '0;
      mask_q  <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      dup_q   <= dup_d;
    end
  end

  // Next-state logic: steer bits into lanes, detect completion and drains.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    dup_d   = dup_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          word_d[bus.sel] = bus.in_bit;
          if (mask_q[bus.sel]) begin
            dup_d = 1'b1;
          end
          mask_d[bus.sel] = 1'b1;
          if (&mask_d) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (drain) begin
          state_d = COLLECT;
          // A write landing on the drain edge starts the next collection,
          // so it can never collide with a lane of the word leaving now.
          mask_d = '0;
          if (accept) begin
            word_d[bus.sel] = bus.in_bit;
            mask_d[bus.sel] = 1'b1;
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Stale lanes are deliberately kept across drains; out is only meaningful
  // while out_valid is high.
  assign bus.out       = word_q;
  assign bus.lane_mask = mask_q;
  assign bus.dup_err   = dup_q;
  assign state_dbg     = (state_q == FULL);

endmodule

// File: tb/tb_demux8_collect.sv
// Directed bench for demux8_collect with hand-computed expectations.
module tb_demux8_collect;

  logic clk;
  logic rst;
  logic state_dbg;
  int   n_checks;
  int   n_fail;

  demux8_collect_if #(.N(8), .SW(3)) bus ();

  demux8_collect #(.N(8), .SW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input transfer with out_ready held low.
  task automatic put_bit(input logic [2:0] s, input logic b);
    bus.sel      = s;
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_out"},  {24'd0, bus.out},       32'h00);
    check({tag, "_mask"}, {24'd0, bus.lane_mask}, 32'h00);
    check({tag, "_ov"},   {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_dup"},  {31'd0, bus.dup_err},   32'd0);
  endtask

  logic [2:0] order4 [8];
  logic       bits4  [8];
  logic       bits1  [8];
  logic       bits6  [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bits1  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    order4 = '{3'd7, 3'd2, 3'd5, 3'd0, 3'd6, 3'd1, 3'd4, 3'd3};
    bits4  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bits6  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset: in_ready must stay low even with out_ready high.
    rst          = 1'b1;
    bus.in_bit   = 1'b0;
    bus.sel      = 3'd0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    tick();
    check("rst_in_ready2", {31'd0, bus.in_ready}, 32'd0);
    check_idle_reset("rst");
    check("rst_state", {31'd0, state_dbg}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    tick();

    // Test 1: in-order fill.
    for (int i = 0; i < 8; i++) begin
      check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
      put_bit(3'(i), bits1[i]);
      if (i < 7) check("t1_ov_early", {31'd0, bus.out_valid}, 32'd0);
    end
    check("t1_ov",       {31'd0, bus.out_valid}, 32'd1);
    check("t1_out",      {24'd0, bus.out},       32'h4D);
    check("t1_mask",     {24'd0, bus.lane_mask}, 32'hFF);
    check("t1_in_ready", {31'd0, bus.in_ready},  32'd0);
    check("t1_state",    {31'd0, state_dbg},     32'd1);

    // Test 2: hold in FULL while in_valid is driven.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.sel    = 3'(i + 1);
      bus.in_bit = ~bus.out[i + 1];
      tick();
      check("t2_out",  {24'd0, bus.out},       32'h4D);
      check("t2_mask", {24'd0, bus.lane_mask}, 32'hFF);
      check("t2_ov",   {31'd0, bus.out_valid}, 32'd1);
      check("t2_dup",  {31'd0, bus.dup_err},   32'd0);
    end

    // Test 3: drain with a simultaneous accept.
    bus.sel       = 3'd3;
    bus.in_bit    = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t3_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("t3_ov",   {31'd0, bus.out_valid}, 32'd0);
    check("t3_mask", {24'd0, bus.lane_mask}, 32'h08);
    check("t3_out3", {31'd0, bus.out[3]},    32'd1);
    check("t3_dup",  {31'd0, bus.dup_err},   32'd0);

    // Reset to start test 4 from an empty collection.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_reset("t4_rst");

    // Test 4: out-of-order fill.
    for (int i = 0; i < 8; i++) begin
      put_bit(order4[i], bits4[i]);
      if (i < 7) check("t4_ov_early", {31'd0, bus.out_valid}, 32'd0);
    end
    check("t4_ov",   {31'd0, bus.out_valid}, 32'd1);
    check("t4_out",  {24'd0, bus.out},       32'hD4);
    check("t4_dup",  {31'd0, bus.dup_err},   32'd0);
    // Plain drain: mask clears, word is retained.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t4_drain_ov",   {31'd0, bus.out_valid}, 32'd0);
    check("t4_drain_mask", {24'd0, bus.lane_mask}, 32'h00);
    check("t4_drain_out",  {24'd0, bus.out},       32'hD4);

    // Test 5: duplicate write to lane 2.
    put_bit(3'd2, 1'b1);
    put_bit(3'd2, 1'b0);
    check("t5_out2", {31'd0, bus.out[2]},    32'd0);
    check("t5_mask", {24'd0, bus.lane_mask}, 32'h04);
    check("t5_dup",  {31'd0, bus.dup_err},   32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i != 2) put_bit(3'(i), 1'b1);
    end
    check("t5_ov",  {31'd0, bus.out_valid}, 32'd1);
    check("t5_out", {24'd0, bus.out},       32'hFB);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t5_drain_ov", {31'd0, bus.out_valid}, 32'd0);
    check("t5_dup_held", {31'd0, bus.dup_err},   32'd1);

    // Test 6: reset mid-collection, then a clean fill.
    for (int i = 0; i < 5; i++) put_bit(3'(i), 1'b1);
    check("t6_mask_part", {24'd0, bus.lane_mask}, 32'h1F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_reset("t6_rst");
    for (int i = 0; i < 8; i++) begin
      put_bit(3'(i), bits6[i]);
      if (i < 7) check("t6_ov_early", {31'd0, bus.out_valid}, 32'd0);
    end
    check("t6_ov",   {31'd0, bus.out_valid}, 32'd1);
    check("t6_out",  {24'd0, bus.out},       32'h96);
    check("t6_mask", {24'd0, bus.lane_mask}, 32'hFF);
    check("t6_dup",  {31'd0, bus.dup_err},   32'd0);

    // Reset while FULL discards the word.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_reset("t7_rst_full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
